load_store_unit: RTL and testbench

- Memory-access engine that produces the `mem_in` operand consumed by the CPU's write-back select stage.
- Takes a decoded load/store request from execute and runs a req/ready handshake with the data memory.
- Steers byte lanes and builds byte enables for stores; aligns and sign/zero-extends load data.
- Holds `busy` high so the pipeline stalls until the access retires.

---
 rtl/rv32_pkg.sv | 12 +
 rtl/lsu_align.sv | 32 +++
 rtl/load_store_unit.sv | 128 ++++++++++++
 tb/tb_load_store_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// rv32_pkg: funct3 width codes and LSU state encoding shared by the load/store unit.
package rv32_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {IDLE, REQ, RESP, ERR, ABORT} lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane steering and byte enables for stores, extraction and extension for loads.
module lsu_align
    import rv32_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  be_o,
    output logic [31:0] rdata_o
);

    logic [31:0] shifted;
    logic [7:0]  sel_b;
    logic [15:0] sel_h;
    logic        sgn;

    always_comb begin
        shifted = rdata_i >> {off_i, 3'b000};
        sel_b   = shifted[7:0];
        sel_h   = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        sgn     = ~funct3_i[2];
        wdata_o = funct3_i[1:0] == F3_B[1:0] ? {4{wdata_i[7:0]}} :
                  funct3_i[1:0] == F3_H[1:0] ? {2{wdata_i[15:0]}} : wdata_i;
        be_o    = funct3_i[1:0] == F3_B[1:0] ? 4'b0001 << off_i :
                  funct3_i[1:0] == F3_H[1:0] ? (off_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        rdata_o = funct3_i[1:0] == F3_B[1:0] ? {{24{sgn & sel_b[7]}}, sel_b} :
                  funct3_i[1:0] == F3_H[1:0] ? {{16{sgn & sel_h[15]}}, sel_h} : rdata_i;
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: req/ready memory access engine with lane steering, load extension
// and a REQ-state watchdog; produces the write-back mem_in operand on load_data.
module load_store_unit
    import rv32_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

    lsu_state_e      state_q;
    logic [TO_W-1:0] cnt_q;
    logic            st_q;
    logic [2:0]      f3_q;
    logic [1:0]      off_q;
    logic [2:0]      al_f3;
    logic [1:0]      al_off;
    logic [31:0]     al_wdata;
    logic [31:0]     al_rdata;
    logic [3:0]      al_be;
    logic            legal;
    logic            aligned;

    // The aligner sees the incoming request in IDLE (store steering) and the latched one afterwards (load extraction).
    assign al_f3   = state_q == IDLE ? funct3 : f3_q;
    assign al_off  = state_q == IDLE ? addr[1:0] : off_q;
    assign legal   = is_store ? funct3 <= F3_W : (funct3 != 3'b011 && funct3[2:1] != 2'b11);
    assign aligned = funct3[1:0] == F3_H[1:0] ? ~addr[0] :
                     funct3[1:0] == F3_W[1:0] ? addr[1:0] == 2'b00 : 1'b1;

    lsu_align u_align (
        .funct3_i (al_f3),
        .off_i    (al_off),
        .wdata_i  (store_data),
        .rdata_i  (mem_rdata),
        .wdata_o  (al_wdata),
        .be_o     (al_be),
        .rdata_o  (al_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            st_q       <= 1'b0;
            f3_q       <= '0;
            off_q      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            load_data  <= '0;
            misaligned <= 1'b0;
            fault      <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (start && legal && aligned) begin
                        state_q   <= REQ;
                        busy      <= 1'b1;
                        mem_req   <= 1'b1;
                        mem_we    <= is_store;
                        mem_addr  <= {addr[31:2], 2'b00};
                        mem_wdata <= al_wdata;
                        mem_be    <= is_store ? al_be : 4'b1111;
                        st_q      <= is_store;
                        f3_q      <= funct3;
                        off_q     <= addr[1:0];
                    end else if (start) begin
                        state_q    <= ERR;
                        done       <= 1'b1;
                        misaligned <= 1'b1;
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        state_q <= RESP;
                        busy    <= 1'b0;
                        mem_req <= 1'b0;
                        done    <= 1'b1;
                        if (!st_q) load_data <= al_rdata;
                    end else if (TIMEOUT_CYCLES != 0 && cnt_q == TO_LAST) begin
                        state_q <= ABORT;
                        busy    <= 1'b0;
                        mem_req <= 1'b0;
                        done    <= 1'b1;
                        fault   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    cnt_q      <= '0;
                    done       <= 1'b0;
                    misaligned <= 1'b0;
                    fault      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed-vector bench for load_store_unit with a 4-cycle watchdog.
module tb_load_store_unit;
    import rv32_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic [31:0] load_data;
    logic        misaligned;
    logic        fault;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    int          r_done_n;
    int          r_req;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_ld;
    logic [3:0]  r_be;
    logic        r_we;
    logic        r_mis;
    logic        r_fault;

    load_store_unit #(.TIMEOUT_CYCLES(4), .TO_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .busy       (busy),
        .done       (done),
        .load_data  (load_data),
        .misaligned (misaligned),
        .fault      (fault),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // One access; mem_ready is high from REQ cycle ready_at onward. Records the first done within 30 cycles.
    task automatic access(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                          input int ready_at);
        @(negedge clk);
        start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = d;
        mem_ready = (ready_at <= 0);
        r_done_n = 0; r_req = 0; r_mis = 1'b0; r_fault = 1'b0; r_ld = 'x;
        for (int n = 1; n <= 30 && r_done_n == 0; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (mem_req) begin
                r_req++; r_addr = mem_addr; r_wdata = mem_wdata; r_be = mem_be; r_we = mem_we;
            end
            if (done) begin
                r_done_n = n; r_mis = misaligned; r_fault = fault; r_ld = load_data;
            end
            mem_ready = (n >= ready_at);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'b000; addr = '0; store_data = '0;
        mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", done); end
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
        n_cmp++; if (load_data !== 32'h0) begin n_bad++; $display("FAIL reset_load_data got=%h exp=0", load_data); end
        n_cmp++; if ({misaligned, fault, mem_we, mem_be} !== 7'b0) begin
            n_bad++; $display("FAIL reset_flags got=%b exp=0", {misaligned, fault, mem_we, mem_be});
        end
        rst = 1'b0;
    endtask

    task automatic test_store_word;
        access(1'b1, F3_W, 32'h100, 32'hDEADBEEF, 0);
        n_cmp++; if (r_req !== 1) begin n_bad++; $display("FAIL sw_req_cycles got=%0d exp=1", r_req); end
        n_cmp++; if (r_addr !== 32'h100) begin n_bad++; $display("FAIL sw_addr got=%h exp=00000100", r_addr); end
        n_cmp++; if (r_be !== 4'b1111) begin n_bad++; $display("FAIL sw_be got=%b exp=1111", r_be); end
        n_cmp++; if (r_we !== 1'b1) begin n_bad++; $display("FAIL sw_we got=%b exp=1", r_we); end
        n_cmp++; if (r_wdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL sw_wdata got=%h exp=deadbeef", r_wdata); end
        n_cmp++; if (r_done_n !== 2) begin n_bad++; $display("FAIL sw_latency got=%0d exp=2", r_done_n); end
        n_cmp++; if (r_ld !== 32'h0) begin n_bad++; $display("FAIL sw_load_data got=%h exp=0", r_ld); end
    endtask

    task automatic test_loads;
        logic [2:0]  f3s  [4] = '{F3_B, F3_BU, F3_H, F3_HU};
        logic [31:0] adrs [4] = '{32'h203, 32'h203, 32'h202, 32'h200};
        logic [31:0] exps [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01};
        for (int i = 0; i < 4; i++) begin
            access(1'b0, f3s[i], adrs[i], 32'h0, 0);
            n_cmp++; if (r_ld !== exps[i]) begin n_bad++; $display("FAIL load_%0d_data got=%h exp=%h", i, r_ld, exps[i]); end
            n_cmp++; if ({r_we, r_be, r_addr} !== {1'b0, 4'b1111, 32'h200}) begin
                n_bad++; $display("FAIL load_%0d_bus got=%b/%b/%h exp=0/1111/00000200", i, r_we, r_be, r_addr);
            end
        end
    endtask

    task automatic test_store_byte;
        access(1'b1, F3_B, 32'h301, 32'h000000AB, 0);
        n_cmp++; if (r_be !== 4'b0010) begin n_bad++; $display("FAIL sb_be got=%b exp=0010", r_be); end
        n_cmp++; if (r_wdata !== 32'hABABABAB) begin n_bad++; $display("FAIL sb_wdata got=%h exp=abababab", r_wdata); end
        n_cmp++; if (r_addr !== 32'h300) begin n_bad++; $display("FAIL sb_addr got=%h exp=00000300", r_addr); end
        n_cmp++; if (r_ld !== 32'h00007F01) begin n_bad++; $display("FAIL sb_load_data got=%h exp=00007f01", r_ld); end
        access(1'b1, F3_H, 32'h302, 32'h0000BEEF, 0);
        n_cmp++; if ({r_be, r_wdata} !== {4'b1100, 32'hBEEFBEEF}) begin
            n_bad++; $display("FAIL sh_lanes got=%b/%h exp=1100/beefbeef", r_be, r_wdata);
        end
    endtask

    task automatic test_misaligned;
        logic        sts  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [2:0]  f3s  [4] = '{F3_W, F3_H, 3'b011, F3_BU};
        logic [31:0] adrs [4] = '{32'h102, 32'h105, 32'h200, 32'h200};
        for (int i = 0; i < 4; i++) begin
            access(sts[i], f3s[i], adrs[i], 32'h0, 0);
            n_cmp++; if ({r_done_n, r_mis, r_fault} !== {32'sd1, 1'b1, 1'b0}) begin
                n_bad++; $display("FAIL err_%0d_done got=%0d/%b/%b exp=1/1/0", i, r_done_n, r_mis, r_fault);
            end
            n_cmp++; if (r_req !== 0) begin n_bad++; $display("FAIL err_%0d_req got=%0d exp=0", i, r_req); end
            n_cmp++; if (r_ld !== 32'h00007F01) begin n_bad++; $display("FAIL err_%0d_load_data got=%h exp=00007f01", i, r_ld); end
        end
    endtask

    task automatic test_timeout;
        access(1'b0, F3_W, 32'h200, 32'h0, 1000);
        n_cmp++; if (r_req !== 4) begin n_bad++; $display("FAIL to_req_cycles got=%0d exp=4", r_req); end
        n_cmp++; if ({r_done_n, r_fault, r_mis} !== {32'sd5, 1'b1, 1'b0}) begin
            n_bad++; $display("FAIL to_fault got=%0d/%b/%b exp=5/1/0", r_done_n, r_fault, r_mis);
        end
        n_cmp++; if (r_ld !== 32'h00007F01) begin n_bad++; $display("FAIL to_load_data got=%h exp=00007f01", r_ld); end
        access(1'b0, F3_W, 32'h200, 32'h0, 4);
        n_cmp++; if ({r_req, r_done_n, r_fault} !== {32'sd4, 32'sd5, 1'b0}) begin
            n_bad++; $display("FAIL to_race got=%0d/%0d/%b exp=4/5/0", r_req, r_done_n, r_fault);
        end
        n_cmp++; if (r_ld !== 32'h80FF7F01) begin n_bad++; $display("FAIL to_race_data got=%h exp=80ff7f01", r_ld); end
    endtask

    task automatic test_reset_mid_access;
        int dones = 0;
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; funct3 = F3_W; addr = 32'h400; mem_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL rst_pre_req got=%b exp=1", mem_req); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if ({mem_req, busy, done} !== 3'b000) begin
            n_bad++; $display("FAIL rst_mid got=%b exp=000", {mem_req, busy, done});
        end
        rst = 1'b0;
        repeat (3) begin @(negedge clk); if (done) dones++; end
        n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL rst_no_done got=%0d exp=0", dones); end
        access(1'b0, F3_W, 32'h200, 32'h0, 0);
        n_cmp++; if ({r_done_n, r_ld} !== {32'sd2, 32'h80FF7F01}) begin
            n_bad++; $display("FAIL rst_after got=%0d/%h exp=2/80ff7f01", r_done_n, r_ld);
        end
    endtask

    task automatic test_back_to_back;
        int reqs = 0;
        int dones = 0;
        logic prev = 1'b0;
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; funct3 = F3_W; addr = 32'h200; mem_ready = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            start = (n == 2 || n == 4);
            if (mem_req && !prev) reqs++;
            prev = mem_req;
            if (done) dones++;
            mem_ready = (n >= 3);
        end
        start = 1'b0;
        n_cmp++; if (reqs !== 1) begin n_bad++; $display("FAIL b2b_reqs got=%0d exp=1", reqs); end
        n_cmp++; if (dones !== 1) begin n_bad++; $display("FAIL b2b_dones got=%0d exp=1", dones); end
    endtask

    initial begin
        mem_rdata = 32'h80FF7F01;
        test_reset;
        test_store_word;
        test_loads;
        test_store_byte;
        test_misaligned;
        test_timeout;
        test_reset_mid_access;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
